// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII receive MAC: FSM states, CRC constants, preamble nibbles.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mii_rx_pkg;

  typedef enum logic [2:0] {
    ST_DROP     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_DATA     = 3'd3,
    ST_END      = 3'd4
  } rx_state_t;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE      = 4'hD;

  // One byte of the reflected IEEE 802.3 CRC, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_crc32.sv
// Byte-wide reflected CRC-32 register; clear reloads the init value.
// Latency: crc reflects a byte one cycle after enable.
// Backpressure: none; updates only when enable is high.
module mii_rx_crc32
  import mii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // Running CRC; clear wins over a same-cycle update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/mii_rx_mac.sv
// MII receive MAC: strips preamble/SFD, checks FCS/length/rxer/alignment, emits bytes with sop/eop/err, FCS removed.
// Latency: a byte leaves 1 cycle after the nibble completing the byte 4 positions later; last byte 1 cycle after END.
// Backpressure: none; consumer must accept every rx_valid strobe. Optional stats under MII_RX_MAC_STATS_EN.
module mii_rx_mac
  import mii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518    // at most 65534 so the saturated count still reads as too long
`ifdef MII_RX_MAC_STATS_EN
  ,
  parameter int STAT_WIDTH = 32
`endif
) (
  input  logic       eth_rxclk,
  input  logic       rstn,
  input  logic       eth_rxdv,
  input  logic       eth_rxer,
  input  logic [3:0] eth_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       rx_crc_err,
  output logic       rx_len_err,
  output logic       rx_busy
`ifdef MII_RX_MAC_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_frames_ok,
  output logic [STAT_WIDTH-1:0] stat_frames_err
`endif
);

  rx_state_t   state, state_nxt;
  logic        sfd_hit;
  logic        byte_done;
  logic        busy_nxt;
  logic        phase;
  logic [3:0]  low_nib;
  logic [15:0] byte_cnt;
  logic        err_flag;
  logic        align_err;
  logic [31:0] fcs_sr;      // last four bytes received; the newest is in [7:0]
  logic [7:0]  hold;
  logic        hold_vld;
  logic        first_pend;
  logic [31:0] crc;
  logic [7:0]  new_byte;
  logic        crc_bad;
  logic        len_bad;
  logic        frame_bad;

  assign new_byte  = {eth_rxd, low_nib};
  assign crc_bad   = (crc != CRC_RESIDUE);
  assign len_bad   = (byte_cnt < 16'(MIN_LEN)) || (byte_cnt > 16'(MAX_LEN)) || align_err;
  assign frame_bad = err_flag || crc_bad || len_bad;

  mii_rx_crc32 u_crc (
    .clk    (eth_rxclk),
    .rstn   (rstn),
    .clear  (sfd_hit),
    .enable (byte_done),
    .data   (new_byte),
    .crc    (crc)
  );

  // State register.
  always_ff @(posedge eth_rxclk or negedge rstn) begin
    if (!rstn) state <= ST_DROP;
    else       state <= state_nxt;
  end

  // Next state plus the per-cycle control strobes derived from it.
  always_comb begin
    state_nxt = state;
    sfd_hit   = 1'b0;
    byte_done = 1'b0;
    case (state)
      ST_DROP: begin
        if (!eth_rxdv) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (eth_rxdv) state_nxt = (eth_rxd == PREAMBLE_NIBBLE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!eth_rxdv)                      state_nxt = ST_IDLE;
        else if (eth_rxer)                  state_nxt = ST_DROP;
        else if (eth_rxd == PREAMBLE_NIBBLE) state_nxt = ST_PREAMBLE;
        else if (eth_rxd == SFD_NIBBLE) begin
          state_nxt = ST_DATA;
          sfd_hit   = 1'b1;
        end else                            state_nxt = ST_DROP;
      end
      ST_DATA: begin
        if (!eth_rxdv) state_nxt = ST_END;
        else           byte_done = phase;
      end
      ST_END: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_DROP;
    endcase
    busy_nxt = (state_nxt == ST_PREAMBLE) || (state_nxt == ST_DATA) || (state_nxt == ST_END);
  end

  // Nibble assembly, byte count, error flags and the 4-byte FCS holdback pipeline.
  always_ff @(posedge eth_rxclk or negedge rstn) begin
    if (!rstn) begin
      phase      <= 1'b0;
      low_nib    <= 4'h0;
      byte_cnt   <= 16'h0;
      err_flag   <= 1'b0;
      align_err  <= 1'b0;
      fcs_sr     <= 32'h0;
      hold       <= 8'h0;
      hold_vld   <= 1'b0;
      first_pend <= 1'b0;
    end else if (sfd_hit) begin
      phase      <= 1'b0;
      byte_cnt   <= 16'h0;
      err_flag   <= 1'b0;
      align_err  <= 1'b0;
      fcs_sr     <= 32'h0;
      hold       <= 8'h0;
      hold_vld   <= 1'b0;
      first_pend <= 1'b1;
    end else if (state == ST_DATA) begin
      if (eth_rxdv) begin
        if (eth_rxer) err_flag <= 1'b1;
        if (!phase) begin
          low_nib <= eth_rxd;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
          if (hold_vld) first_pend <= 1'b0;
          hold   <= fcs_sr[31:24];
          fcs_sr <= {fcs_sr[23:0], new_byte};
          // Fifth byte onwards: the oldest FCS slot now holds real payload.
          if (byte_cnt >= 16'd4) hold_vld <= 1'b1;
        end
      end else if (phase) begin
        align_err <= 1'b1;
      end
    end else if (state == ST_END) begin
      hold_vld <= 1'b0;
    end
  end

  // Registered output strobes; pulses default low every cycle.
  always_ff @(posedge eth_rxclk or negedge rstn) begin
    if (!rstn) begin
      rx_data    <= 8'h0;
      rx_valid   <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      rx_err     <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_len_err <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      rx_err     <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_len_err <= 1'b0;
      rx_busy    <= busy_nxt;
      if (byte_done && hold_vld) begin
        rx_valid <= 1'b1;
        rx_data  <= hold;
        rx_sop   <= first_pend;
      end
      if (state == ST_END) begin
        if (hold_vld) begin
          rx_valid <= 1'b1;
          rx_data  <= hold;
          rx_sop   <= first_pend;
          rx_eop   <= 1'b1;
          rx_err   <= frame_bad;
        end
        rx_crc_err <= crc_bad;
        rx_len_err <= len_bad;
      end
    end
  end

`ifdef MII_RX_MAC_STATS_EN
  // Saturating good/bad frame counters, bumped as END resolves the frame.
  always_ff @(posedge eth_rxclk or negedge rstn) begin
    if (!rstn) begin
      stat_frames_ok  <= '0;
      stat_frames_err <= '0;
    end else if (state == ST_END) begin
      if (frame_bad) begin
        if (stat_frames_err != '1) stat_frames_err <= stat_frames_err + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        if (stat_frames_ok != '1) stat_frames_ok <= stat_frames_ok + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: doc/mii_rx_mac.md
Name: mii_rx_mac

Overview:
- MII receive MAC, the receive-direction counterpart of the team's MII transmit MAC.
- Decodes the nibble stream from the PHY and strips preamble/SFD.
- Checks FCS, length, PHY errors and alignment, then emits a byte stream with sop/eop/err framing, FCS removed.
- Runs entirely in the PHY receive clock domain; CDC and buffering belong to the downstream consumer.

Parameters:
MIN_LEN, 64, minimum frame bytes after SFD, FCS included
MAX_LEN, 1518, maximum frame bytes after SFD, FCS included; must be ≤ 65534
STAT_WIDTH, 32, width of statistics counters (RX_STATS_EN only)

Ports:
eth_rxclk  in  1  MII receive clock; the only clock
rstn  in  1  reset, asynchronous, active-low
eth_rxdv  in  1  MII receive data valid
eth_rxer  in  1  MII receive error
eth_rxd  in  4  MII receive nibble, low nibble of each byte first
rx_data  out  8  output byte
rx_valid  out  1  one-cycle strobe, rx_data valid
rx_sop  out  1  first payload byte, qualified by rx_valid
rx_eop  out  1  last payload byte, qualified by rx_valid
rx_err  out  1  frame bad, qualified by rx_valid & rx_eop
rx_crc_err  out  1  one-cycle pulse at frame end: FCS mismatch
rx_len_err  out  1  one-cycle pulse at frame end: length or alignment error
rx_busy  out  1  high in PREAMBLE, DATA, END

Behaviour:
- Reset: all outputs 0; state DROP; CRC register 0xFFFFFFFF.
- All outputs are registered.
- States: DROP, IDLE, PREAMBLE, DATA, END.
- DROP: wait for eth_rxdv=0, then go to IDLE. This prevents locking onto a frame that was already in progress when reset released.
- IDLE: eth_rxdv=1 & eth_rxd=0x5 → PREAMBLE. Any other eth_rxdv=1 nibble → DROP.
- PREAMBLE:
  - 0x5 → stay.
  - 0xD → DATA; clear nibble phase, byte count, err flag, hold/FCS pipeline, CRC.
  - Any other nibble, or eth_rxer=1 → DROP.
  - eth_rxdv=0 → IDLE.
  - No output is produced in any of these cases.
- DATA, nibble assembly:
  - Phase 0 latches the low nibble.
  - Phase 1 forms byte {eth_rxd, low}, feeds the CRC, and increments the 16-bit byte count (saturating at 0xFFFF).
- DATA, pipeline per new byte:
  - If the hold register is valid, emit it (rx_valid=1; rx_sop=1 if it is the first emission).
  - The hold register then takes the oldest byte of the 4-byte FCS shift register.
  - The new byte shifts into the FCS shift register.
  - The hold register becomes valid once 5 bytes have been received.
  - rx_valid fires in the cycle after the completing nibble; at most one strobe per 2 cycles.
- eth_rxer=1 in any DATA cycle sets the sticky err flag.
- eth_rxdv=0 in DATA → END. If the phase was 1 (odd nibble count), set the alignment error.
- END (exactly one cycle):
  - If the hold register is valid, emit it with rx_eop=1 and rx_err = OR of all error flags.
  - rx_crc_err and rx_len_err pulse in the same cycle regardless of whether any byte was emitted.
  - Then go to IDLE.
- Frames of ≤4 bytes emit nothing; only the error pulses fire.
- CRC: IEEE 802.3, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over every byte after SFD including the FCS. The frame is good iff the final register equals residue 0xDEBB20E3.
- rx_len_err conditions: byte count < MIN_LEN, byte count > MAX_LEN, or alignment error. The counter keeps saturating past MAX_LEN and no truncation occurs.
- Back-to-back frames: END→IDLE takes 1 cycle. An MII inter-frame gap of ≥1 cycle is sufficient.
- Reset asserted mid-frame: outputs clear immediately and no eop is produced for the aborted frame.

Optional Feature:
- Macro: MII_RX_MAC_STATS_EN.
- When defined:
  - Adds outputs stat_frames_ok and stat_frames_err, each STAT_WIDTH bits, saturating, reset to 0.
  - Exactly one of the two increments in the cycle after END.
  - A frame is counted as error if rx_err, rx_crc_err or rx_len_err was set for it.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mii_rx_pkg:
  - State encoding.
  - CRC_POLY_REFL=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3.
  - PREAMBLE_NIBBLE=0x5, SFD_NIBBLE=0xD.
- Sub-module mii_rx_crc32:
  - Byte-wide reflected CRC update register.
  - Ports: clk, rstn, clear, enable, data[7:0], crc[31:0].

Test Plan:
1. 7×0x55+0xD5, 60 payload bytes 0x00..0x3B, correct FCS → 60 rx_valid strobes; rx_sop on 0x00, rx_eop on 0x3B, rx_err=0; no error pulses.
2. Same frame with byte 0x10 flipped to 0x11 → 60 bytes out; rx_eop with rx_err=1; rx_crc_err pulse; rx_len_err=0.
3. 40-byte frame with valid FCS → 36 bytes out; rx_err=1; rx_len_err=1; rx_crc_err=0.
4. Good 64-byte frame with eth_rxer high for one nibble at byte 20 → rx_err=1 at eop; both pulse outputs 0.
5. Good frame plus one extra low nibble before eth_rxdv falls → rx_err=1; rx_len_err=1.
6. rstn pulsed low at byte 30 of a frame and released while eth_rxdv is still high → no output for the rest of that frame; the next good frame is received intact. With MII_RX_MAC_STATS_EN defined: stat_frames_ok increments by 1 only for the intact frame.
